// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard controller:
// forward-select encoding, destination-tag layout and the tag match helper.
package fwd_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = $clog2(NREG);

  // XZR reads as zero, so it can never be a real producer of a value
  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(31);

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_WB    = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } tag_t;

  // A stage entry produces register r when it is live, writes, targets r, and r is not XZR
  function automatic logic tag_match(input logic             valid,
                                     input logic             regwrite,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] r);
    return valid & regwrite & (rd == r) & (r != ZERO_REG);
  endfunction

endpackage

// File: rtl/forward_hazard_ctrl_if.sv
// ID-stage <-> hazard controller bundle. The ID stage is the master (drives the
// decoded instruction and flush); the controller is the slave (returns stall,
// forward selects, stall count and the WB tag for retire visibility).
interface forward_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import fwd_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_Rn;
  logic [REG_W-1:0] id_Rm;
  logic             id_useA;
  logic             id_useB;
  logic [REG_W-1:0] id_Rd;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic             flush;

  logic             stall;
  fwd_sel_t         ForwardA;
  fwd_sel_t         ForwardB;
  logic [CNT_W-1:0] stall_count;
  tag_t             wb_tag;

  modport master (
    output id_valid, id_Rn, id_Rm, id_useA, id_useB, id_Rd,
           id_RegWrite, id_MemRead, flush,
    input  stall, ForwardA, ForwardB, stall_count, wb_tag
  );

  modport slave (
    input  id_valid, id_Rn, id_Rm, id_useA, id_useB, id_Rd,
           id_RegWrite, id_MemRead, flush,
    output stall, ForwardA, ForwardB, stall_count, wb_tag
  );

endinterface

// File: rtl/fwd_select.sv
// Per-operand forward select and load-use detection. EX/MEM wins over MEM/WB
// because it holds the newer value of the register.
module fwd_select
  import fwd_pkg::*;
(
  input  logic             use_i,
  input  logic [REG_W-1:0] src_i,
  input  tag_t             ex_t_i,
  input  tag_t             mem_t_i,
  output fwd_sel_t         sel_o,
  output logic             load_hazard_o
);

  logic exHit;
  logic memHit;
  logic unusedMemRead;

  // The MEM-stage load flag is irrelevant here: by MEM the loaded value is forwardable
  assign unusedMemRead = mem_t_i.memread;

  assign exHit  = use_i & tag_match(ex_t_i.valid, ex_t_i.regwrite, ex_t_i.rd, src_i);
  assign memHit = use_i & tag_match(mem_t_i.valid, mem_t_i.regwrite, mem_t_i.rd, src_i);

  // A load still in EX has no data yet, so a dependent operand must wait one cycle
  assign load_hazard_o = exHit & ex_t_i.memread;

  // Pick the youngest producer of the operand, falling back to the register file
  always_comb begin
    sel_o = FWD_REG;
    if (exHit) begin
      sel_o = FWD_EXMEM;
    end else if (memHit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding / load-use hazard controller at the ID/EX boundary. Tracks the
// destination tags of the EX, MEM and WB stages, registers the forward selects
// so they line up with the instruction entering EX, and counts stall cycles.
module forward_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  forward_hazard_ctrl_if.slave  bus
);

  tag_t             ex_t_q, mem_t_q, wb_t_q;
  tag_t             ex_t_d;
  fwd_sel_t         fwdA_q, fwdB_q;
  fwd_sel_t         fwdA_d, fwdB_d;
  fwd_sel_t         selA, selB;
  logic             hazA, hazB;
  logic             stallNow;
  logic             bubble;
  logic [CNT_W-1:0] stallCount_q;

  fwd_select u_selA (
    .use_i         (bus.id_useA),
    .src_i         (bus.id_Rn),
    .ex_t_i        (ex_t_q),
    .mem_t_i       (mem_t_q),
    .sel_o         (selA),
    .load_hazard_o (hazA)
  );

  fwd_select u_selB (
    .use_i         (bus.id_useB),
    .src_i         (bus.id_Rm),
    .ex_t_i        (ex_t_q),
    .mem_t_i       (mem_t_q),
    .sel_o         (selB),
    .load_hazard_o (hazB)
  );

  // Stall is purely combinational; a flush kills the consumer so it never stalls
  assign stallNow = bus.id_valid & ~bus.flush & (hazA | hazB);

  // Decide what enters EX next: the ID instruction and its selects, or a bubble
  always_comb begin
    bubble = bus.flush | stallNow | ~bus.id_valid;
    ex_t_d = '0;
    fwdA_d = FWD_REG;
    fwdB_d = FWD_REG;
    if (!bubble) begin
      ex_t_d.valid    = 1'b1;
      ex_t_d.rd       = bus.id_Rd;
      ex_t_d.regwrite = bus.id_RegWrite;
      ex_t_d.memread  = bus.id_MemRead;
      fwdA_d          = selA;
      fwdB_d          = selB;
    end
  end

  // Shadow pipeline of destination tags plus the registered forward selects
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_t_q  <= '0;
      mem_t_q <= '0;
      wb_t_q  <= '0;
      fwdA_q  <= FWD_REG;
      fwdB_q  <= FWD_REG;
    end else begin
      ex_t_q  <= ex_t_d;
      mem_t_q <= ex_t_q;
      wb_t_q  <= mem_t_q;
      fwdA_q  <= fwdA_d;
      fwdB_q  <= fwdB_d;
    end
  end

  // Stall cycle counter that sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount_q <= '0;
    end else if (stallNow && (stallCount_q != {CNT_W{1'b1}})) begin
      stallCount_q <= stallCount_q + 1'b1;
    end
  end

  assign bus.stall       = stallNow;
  assign bus.ForwardA    = fwdA_q;
  assign bus.ForwardB    = fwdB_q;
  assign bus.stall_count = stallCount_q;
  assign bus.wb_tag      = wb_t_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Testbench for forward_hazard_ctrl. Two instances share all stimulus: one with
// the full 32-bit counter and one with a 4-bit counter for saturation. The
// reference model keeps a list of in-flight instructions (youngest first) and
// looks up the nearest producer of each source register.
module tb_forward_hazard_ctrl;
  import fwd_pkg::*;

  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit mr;
  } inflight_t;

  logic       clk;
  logic       reset;
  logic       idValid, useA, useB, regWrite, memRead, flush;
  logic [4:0] rn, rm, rd;

  int unsigned testsRun    = 0;
  int unsigned testsFailed = 0;

  inflight_t   pipe[$];
  bit          modelKnown = 0;
  logic [31:0] expCnt32   = '0;
  logic [3:0]  expCnt4    = '0;

  forward_hazard_ctrl_if #(.CNT_W(32)) bus32 ();
  forward_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus32.id_valid    = idValid;
  assign bus32.id_Rn       = rn;
  assign bus32.id_Rm       = rm;
  assign bus32.id_useA     = useA;
  assign bus32.id_useB     = useB;
  assign bus32.id_Rd       = rd;
  assign bus32.id_RegWrite = regWrite;
  assign bus32.id_MemRead  = memRead;
  assign bus32.flush       = flush;

  assign bus4.id_valid     = idValid;
  assign bus4.id_Rn        = rn;
  assign bus4.id_Rm        = rm;
  assign bus4.id_useA      = useA;
  assign bus4.id_useB      = useB;
  assign bus4.id_Rd        = rd;
  assign bus4.id_RegWrite  = regWrite;
  assign bus4.id_MemRead   = memRead;
  assign bus4.flush        = flush;

  forward_hazard_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  forward_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a wedged run still terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Distance (0 = EX, 1 = MEM) of the nearest in-flight writer of r, or -1
  function automatic int producerAge(input int r);
    if (r == 31) return -1;
    for (int i = 0; i < 2; i++) begin
      if (i < pipe.size() && pipe[i].valid && pipe[i].rw && pipe[i].rd == r) return i;
    end
    return -1;
  endfunction

  function automatic int expectSel(input bit used, input int r);
    int age;
    if (!used) return 0;
    age = producerAge(r);
    if (age == 0) return 2;
    if (age == 1) return 1;
    return 0;
  endfunction

  function automatic bit expectHazard(input bit used, input int r);
    if (!used) return 0;
    return (producerAge(r) == 0) && pipe[0].mr;
  endfunction

  // One clock cycle: drive ID, check stall, clock, check registered outputs
  task automatic applyStimulus(input bit rst, input bit v, input int srcN, input int srcM,
                               input bit ua, input bit ub, input int dst, input bit rw,
                               input bit mr, input bit fl,
                               output bit modelStall, output bit dutStall);
    int        expA, expB;
    inflight_t e;
    reset    = rst;
    idValid  = v;
    rn       = 5'(srcN);
    rm       = 5'(srcM);
    useA     = ua;
    useB     = ub;
    rd       = 5'(dst);
    regWrite = rw;
    memRead  = mr;
    flush    = fl;
    #1;
    modelStall = v && !fl && (expectHazard(ua, srcN) || expectHazard(ub, srcM));
    dutStall   = bus32.stall;
    if (modelKnown) begin
      checkOutput("stall", 32'(bus32.stall), 32'(modelStall));
      checkOutput("stall_w4", 32'(bus4.stall), 32'(modelStall));
    end
    if (!v || fl || modelStall) begin
      expA = 0;
      expB = 0;
    end else begin
      expA = expectSel(ua, srcN);
      expB = expectSel(ub, srcM);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pipe.delete();
      expCnt32   = '0;
      expCnt4    = '0;
      expA       = 0;
      expB       = 0;
      modelKnown = 1;
    end else begin
      e.valid = v && !fl && !modelStall;
      e.rd    = dst;
      e.rw    = rw;
      e.mr    = mr;
      pipe.push_front(e);
      if (pipe.size() > 3) void'(pipe.pop_back());
      if (modelStall && expCnt32 != 32'hFFFF_FFFF) expCnt32++;
      if (modelStall && expCnt4 != 4'hF) expCnt4++;
    end
    checkOutput("ForwardA", 32'(bus32.ForwardA), 32'(expA));
    checkOutput("ForwardB", 32'(bus32.ForwardB), 32'(expB));
    checkOutput("stall_count", bus32.stall_count, expCnt32);
    checkOutput("stall_count_w4", 32'(bus4.stall_count), 32'(expCnt4));
    checkOutput("wb_valid", 32'(bus32.wb_tag.valid),
                32'((pipe.size() > 2) ? pipe[2].valid : 1'b0));
    @(negedge clk);
  endtask

  // Present one instruction, re-presenting it while the model says ID is held
  task automatic issue(input bit v, input int srcN, input int srcM, input bit ua, input bit ub,
                       input int dst, input bit rw, input bit mr, input bit fl,
                       output int dutStallCycles);
    bit ms, ds;
    int tries;
    dutStallCycles = 0;
    tries = 0;
    applyStimulus(0, v, srcN, srcM, ua, ub, dst, rw, mr, fl, ms, ds);
    if (ds) dutStallCycles++;
    while (ms && tries < 4) begin
      tries++;
      applyStimulus(0, v, srcN, srcM, ua, ub, dst, rw, mr, fl, ms, ds);
      if (ds) dutStallCycles++;
    end
    if (ms) checkOutput("stall_bound", 32'(ms), 32'd0);
  endtask

  initial begin
    bit ms, ds;
    int sc;
    int regs[5] = '{1, 2, 3, 9, 31};

    // Reset held two cycles with live RegWrite traffic
    applyStimulus(1, 1, 1, 2, 1, 1, 1, 1, 0, 0, ms, ds);
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, ms, ds);
    checkOutput("reset_stall", 32'(bus32.stall), 32'd0);

    // EX/MEM forward: ADD X1,X2,X3 ; SUB X4,X1,X1
    issue(1, 2, 3, 1, 1, 1, 1, 0, 0, sc);
    issue(1, 1, 1, 1, 1, 4, 1, 0, 0, sc);
    checkOutput("exmem_A", 32'(bus32.ForwardA), 32'd2);
    checkOutput("exmem_B", 32'(bus32.ForwardB), 32'd2);

    // WB forward: ADD X5 ; unrelated ; ORR X6,X5,X7
    issue(1, 2, 3, 1, 1, 5, 1, 0, 0, sc);
    issue(1, 12, 13, 1, 1, 14, 1, 0, 0, sc);
    issue(1, 5, 7, 1, 1, 6, 1, 0, 0, sc);
    checkOutput("wb_A", 32'(bus32.ForwardA), 32'd1);
    checkOutput("wb_B", 32'(bus32.ForwardB), 32'd0);

    // Load-use: LDUR X9,[X1] ; ADD X10,X9,X2 -> exactly one stall, then WB forward
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ms, ds);
    issue(1, 1, 0, 1, 0, 9, 1, 1, 0, sc);
    issue(1, 9, 2, 1, 1, 10, 1, 0, 0, sc);
    checkOutput("loaduse_cycles", 32'(sc), 32'd1);
    checkOutput("loaduse_A", 32'(bus32.ForwardA), 32'd1);
    checkOutput("loaduse_count", bus32.stall_count, 32'd1);

    // Both operands on the same load still cost one stall
    issue(1, 1, 0, 1, 0, 3, 1, 1, 0, sc);
    issue(1, 3, 3, 1, 1, 4, 1, 0, 0, sc);
    checkOutput("dual_cycles", 32'(sc), 32'd1);
    checkOutput("dual_AB", 32'({bus32.ForwardA, bus32.ForwardB}), 32'h5);

    // XZR never forwards
    issue(1, 2, 3, 1, 1, 31, 1, 0, 0, sc);
    issue(1, 31, 31, 1, 1, 2, 1, 0, 0, sc);
    checkOutput("xzr_AB", 32'({bus32.ForwardA, bus32.ForwardB}), 32'h0);

    // Flush beats a load-use hazard
    issue(1, 1, 0, 1, 0, 3, 1, 1, 0, sc);
    issue(1, 3, 0, 1, 0, 4, 1, 0, 1, sc);
    checkOutput("flush_cycles", 32'(sc), 32'd0);

    // Reset while a hazard is pending: stall drops right after the reset edge
    issue(1, 1, 0, 1, 0, 8, 1, 1, 0, sc);
    applyStimulus(1, 1, 8, 0, 1, 0, 4, 1, 0, 0, ms, ds);
    checkOutput("midreset_stall_during", 32'(ds), 32'd1);
    applyStimulus(0, 1, 8, 0, 1, 0, 4, 1, 0, 0, ms, ds);
    checkOutput("midreset_stall_after", 32'(ds), 32'd0);

    // Randomized mix over a small register pool to provoke hazards
    for (int i = 0; i < 300; i++) begin
      bit v, fl, mr, rw;
      v  = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 9) == 0);
      mr = ($urandom_range(0, 3) == 0);
      rw = mr || ($urandom_range(0, 3) != 0);
      issue(v, regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
            1'($urandom), 1'($urandom), regs[$urandom_range(0, 4)], rw, mr, fl, sc);
    end

    // Twenty load-use pairs drive the 4-bit counter into saturation
    for (int i = 0; i < 20; i++) begin
      issue(1, 1, 0, 1, 0, 9, 1, 1, 0, sc);
      issue(1, 9, 2, 1, 1, 10, 1, 0, 0, sc);
    end
    checkOutput("saturate_w4", 32'(bus4.stall_count), 32'hF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
